axis_result_tx: RTL and testbench

AXIS_RESULT_TX -- requirements
Module: axis_result_tx

---
 rtl/axis_result_tx.sv | 156 +++++++++++++++
 tb/tb_axis_result_tx.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_result_tx.sv
// Requantizes signed accumulator lanes (ReLU, shift, zero-point, saturate) into
// signed bytes and streams them out over AXI4-Stream in fixed-size tiles.
module axis_result_tx #(
  parameter int ARRAY_COLS = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_load,
  input  logic [4:0]                       cfg_shift,
  input  logic [7:0]                       cfg_zero_point,
  input  logic                             cfg_relu_en,
  input  logic [15:0]                      cfg_tile_beats,
  input  logic                             acc_valid,
  output logic                             acc_ready,
  input  logic [ARRAY_COLS*ACC_WIDTH-1:0]  acc_data,
  output logic [ARRAY_COLS*OUT_WIDTH-1:0]  m_axis_tdata,
  output logic [ARRAY_COLS*OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             busy,
  output logic                             tile_done,
  output logic                             cfg_err,
  output logic [31:0]                      beats_sent
);

  localparam int DW = ARRAY_COLS * OUT_WIDTH;
  localparam int AW = ARRAY_COLS * ACC_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [4:0]      shift_q;
  logic [7:0]      zp_q;
  logic            relu_q;
  logic [15:0]     tile_q;
  logic            cfg_err_q;
  logic            s1_valid;
  logic [AW-1:0]   s1_data;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     beat_cnt;
  logic [31:0]     beats_sent_q;

  logic [AW-1:0]   relu_data;
  logic [DW-1:0]   q_data;
  logic [CW-1:0]   pending;
  logic            acc_fire;
  logic            out_fire;
  logic            last_beat;
  logic            cfg_ok;

  function automatic logic [OUT_WIDTH-1:0] quantize(input logic signed [ACC_WIDTH-1:0] v,
                                                    input logic [4:0] sh,
                                                    input logic [7:0] zp);
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] sum;
    shifted = v >>> sh;
    sum = shifted + {{(ACC_WIDTH-8){zp[7]}}, zp};
    if (sum > SAT_MAX)
      return SAT_MAX[OUT_WIDTH-1:0];
    else if (sum < SAT_MIN)
      return SAT_MIN[OUT_WIDTH-1:0];
    return sum[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    relu_data = acc_data;
    for (int i = 0; i < ARRAY_COLS; i++)
      if (relu_q && acc_data[ACC_WIDTH*i + ACC_WIDTH-1])
        relu_data[ACC_WIDTH*i +: ACC_WIDTH] = '0;
  end

  always_comb begin
    q_data = '0;
    for (int i = 0; i < ARRAY_COLS; i++)
      q_data[OUT_WIDTH*i +: OUT_WIDTH] = quantize(s1_data[ACC_WIDTH*i +: ACC_WIDTH], shift_q, zp_q);
  end

  // Beats in stage 1 already own a FIFO slot, so stage 2 can never overflow it.
  assign pending       = count + {{PW{1'b0}}, s1_valid};
  assign acc_ready     = (state == RUN) && (pending < CW'(FIFO_DEPTH));
  assign acc_fire      = acc_valid && acc_ready;
  assign m_axis_tvalid = (count != '0);
  assign out_fire      = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = mem[rd_ptr];
  assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;
  assign last_beat     = (beat_cnt == tile_q - 16'd1);
  assign m_axis_tlast  = m_axis_tvalid && last_beat;
  assign tile_done     = out_fire && last_beat;
  assign busy          = s1_valid || (count != '0) || (beat_cnt != '0);
  assign cfg_ok        = cfg_load && (cfg_tile_beats != '0) && !busy;
  assign cfg_err       = cfg_err_q;
  assign beats_sent    = beats_sent_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shift_q      <= '0;
      zp_q         <= '0;
      relu_q       <= 1'b0;
      tile_q       <= '0;
      cfg_err_q    <= 1'b0;
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      beat_cnt     <= '0;
      beats_sent_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      cfg_err_q <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        state   <= RUN;
        shift_q <= cfg_shift;
        zp_q    <= cfg_zero_point;
        relu_q  <= cfg_relu_en;
        tile_q  <= cfg_tile_beats;
      end

      s1_valid <= acc_fire;
      if (acc_fire)
        s1_data <= relu_data;

      if (s1_valid) begin
        mem[wr_ptr] <= q_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (out_fire)
        rd_ptr <= rd_ptr + PW'(1);

      case ({s1_valid, out_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (out_fire) begin
        beat_cnt     <= last_beat ? 16'd0 : beat_cnt + 16'd1;
        beats_sent_q <= beats_sent_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_result_tx.sv
// Randomized and directed bench for axis_result_tx, checked every cycle against
// a queue-based model of accepted-but-undelivered beats.
module tb_axis_result_tx;
  localparam int COLS  = 8;
  localparam int AWID  = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_load;
  logic [4:0]       cfg_shift;
  logic [7:0]       cfg_zero_point;
  logic             cfg_relu_en;
  logic [15:0]      cfg_tile_beats;
  logic             acc_valid;
  logic             acc_ready;
  logic [COLS*AWID-1:0] acc_data;
  logic [63:0]      m_axis_tdata;
  logic [7:0]       m_axis_tkeep;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             busy;
  logic             tile_done;
  logic             cfg_err;
  logic [31:0]      beats_sent;

  always #5 clk = ~clk;

  axis_result_tx #(.ARRAY_COLS(COLS), .ACC_WIDTH(AWID), .OUT_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_shift(cfg_shift),
    .cfg_zero_point(cfg_zero_point), .cfg_relu_en(cfg_relu_en), .cfg_tile_beats(cfg_tile_beats),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .busy(busy),
    .tile_done(tile_done), .cfg_err(cfg_err), .beats_sent(beats_sent)
  );

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  int    done_seen = 0;
  int    err_seen = 0;

  bit          m_run;
  int          m_shift, m_zp, m_tile, m_cnt;
  bit          m_relu;
  logic [31:0] m_sent;
  bit          pend_err;
  beat_t       q[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One output byte: optional ReLU, floor division by 2^shift, offset, 32-bit wrap, clamp.
  function automatic logic [7:0] q8(input int v, input int sh, input int zp, input bit relu);
    longint x;
    x = v;
    if (relu && x < 0) x = 0;
    x = x >>> sh;
    x = longint'(int'(x + zp));
    if (x > 127) x = 127;
    else if (x < -128) x = -128;
    return 8'(x);
  endfunction

  function automatic logic [COLS*AWID-1:0] pack(input int a[8]);
    logic [COLS*AWID-1:0] d;
    for (int i = 0; i < COLS; i++) d[AWID*i +: AWID] = a[i];
    return d;
  endfunction

  function automatic logic [COLS*AWID-1:0] rand_data();
    logic [COLS*AWID-1:0] d;
    for (int i = 0; i < COLS; i++)
      d[AWID*i +: AWID] = ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 8000)) - 4000);
    return d;
  endfunction

  always @(negedge clk) begin
    bit          exp_busy, exp_ready, exp_tvalid, exp_done;
    logic [63:0] ed;
    beat_t       b;
    if (mon_en) begin
      exp_busy   = (q.size() != 0) || (m_cnt != 0);
      exp_ready  = m_run && (q.size() < DEPTH);
      exp_tvalid = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
      exp_done   = exp_tvalid && m_axis_tready && (m_cnt == m_tile - 1);
      checkOutput("acc_ready", acc_ready, exp_ready);
      checkOutput("busy", busy, exp_busy);
      checkOutput("tvalid", m_axis_tvalid, exp_tvalid);
      checkOutput("tile_done", tile_done, exp_done);
      checkOutput("cfg_err", cfg_err, pend_err);
      checkOutput("beats_sent", beats_sent, m_sent);
      if (exp_tvalid && m_axis_tvalid) begin
        checkOutput("tdata", m_axis_tdata, q[0].data);
        checkOutput("tkeep", m_axis_tkeep, 8'hFF);
        checkOutput("tlast", m_axis_tlast, m_cnt == m_tile - 1);
      end
      if (tile_done) done_seen++;
      if (cfg_err) err_seen++;

      if (rst) begin
        q.delete();
        m_run = 0; m_shift = 0; m_zp = 0; m_relu = 0; m_tile = 0; m_cnt = 0;
        m_sent = '0; pend_err = 0;
      end else begin
        if (acc_valid && exp_ready) begin
          for (int i = 0; i < COLS; i++)
            ed[8*i +: 8] = q8(int'(acc_data[AWID*i +: AWID]), m_shift, m_zp, m_relu);
          b.data = ed;
          b.cyc  = cyc;
          q.push_back(b);
        end
        if (exp_tvalid && m_axis_tready) begin
          void'(q.pop_front());
          m_sent = m_sent + 32'd1;
          m_cnt  = (m_cnt == m_tile - 1) ? 0 : m_cnt + 1;
        end
        pend_err = 0;
        if (cfg_load) begin
          if (cfg_tile_beats != 0 && !exp_busy) begin
            m_run = 1; m_shift = cfg_shift; m_zp = int'($signed(cfg_zero_point));
            m_relu = cfg_relu_en; m_tile = cfg_tile_beats;
          end else
            pend_err = 1;
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int sh, input logic [7:0] zp, input bit relu, input int tile);
    cfg_shift = 5'(sh); cfg_zero_point = zp; cfg_relu_en = relu; cfg_tile_beats = 16'(tile);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic applyStimulus(input logic [COLS*AWID-1:0] d);
    int t = 0;
    acc_valid = 1'b1;
    acc_data  = d;
    while (!acc_ready && t < 200) begin tick(); t++; end
    if (!acc_ready) checkOutput("accept_timeout", 1'b0, 1'b1);
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    acc_valid = 1'b0;
    m_axis_tready = 1'b1;
    while ((busy || m_axis_tvalid) && t < 500) begin tick(); t++; end
    if (busy) checkOutput("idle_timeout", busy, 1'b0);
  endtask

  task automatic run_random(input int n);
    int  sent = 0;
    int  guard = 0;
    bit  fire;
    while (sent < n && guard < 2000) begin
      acc_valid     = ($urandom_range(0, 3) != 0);
      acc_data      = rand_data();
      m_axis_tready = ($urandom_range(0, 3) != 0);
      fire = acc_valid && acc_ready;
      tick();
      if (fire) sent++;
      guard++;
    end
    acc_valid = 1'b0;
    checkOutput("random_sent", 64'(sent), 64'(n));
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int                   v[8];
    logic [COLS*AWID-1:0] sd[6];
    int                   k, d0, e0;
    bit                   fire;

    rst = 1'b1; cfg_load = 1'b0; cfg_shift = '0; cfg_zero_point = '0; cfg_relu_en = 1'b0;
    cfg_tile_beats = '0; acc_valid = 1'b0; acc_data = '0; m_axis_tready = 1'b1;
    m_run = 0; m_shift = 0; m_zp = 0; m_relu = 0; m_tile = 0; m_cnt = 0; m_sent = '0; pend_err = 0;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("reset_acc_ready", acc_ready, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_beats_sent", beats_sent, 32'd0);
    checkOutput("reset_tdata", m_axis_tdata, 64'd0);
    checkOutput("reset_tlast", m_axis_tlast, 1'b0);

    // Saturating shift, single-beat tiles.
    load_cfg(4, 8'd0, 1'b0, 1);
    v = '{256, -256, 5000, -5000, 16, -17, 0, 2047};
    applyStimulus(pack(v));
    checkOutput("lat_tvalid_n1", m_axis_tvalid, 1'b0);
    tick();
    checkOutput("lat_tvalid_n2", m_axis_tvalid, 1'b1);
    checkOutput("vec1_tdata", m_axis_tdata, 64'h7F00FE01807FF010);
    checkOutput("vec1_tlast", m_axis_tlast, 1'b1);
    checkOutput("vec1_tile_done", tile_done, 1'b1);
    wait_idle();

    // ReLU with a negative zero point.
    load_cfg(0, 8'hFD, 1'b1, 1);
    v = '{-50, 10, 200, 0, -1, 130, -128, 3};
    applyStimulus(pack(v));
    tick();
    checkOutput("vec2_tdata", m_axis_tdata, 64'h00FD7FFDFD7F07FD);
    wait_idle();

    // Downstream stall: only the buffer's worth of beats gets in.
    rst = 1'b1; tick(); rst = 1'b0;
    load_cfg(2, 8'd1, 1'b0, 2);
    for (int i = 0; i < 6; i++) sd[i] = rand_data();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      m_axis_tready = 1'b0;
      acc_valid = (k < 6);
      acc_data  = sd[k % 6];
      fire = acc_valid && acc_ready;
      tick();
      if (fire) k++;
    end
    checkOutput("stall_accepted", 64'(k), 64'd4);
    checkOutput("stall_acc_ready", acc_ready, 1'b0);
    m_axis_tready = 1'b1;
    for (int c = 0; c < 50 && k < 6; c++) begin
      acc_valid = 1'b1;
      acc_data  = sd[k];
      fire = acc_ready;
      tick();
      if (fire) k++;
    end
    wait_idle();
    checkOutput("stall_beats_sent", beats_sent, 32'd6);

    // Partial tile keeps the block busy until completed.
    load_cfg(1, 8'd5, 1'b0, 3);
    d0 = done_seen;
    for (int i = 0; i < 7; i++) applyStimulus(rand_data());
    repeat (4) tick();
    checkOutput("partial_busy", busy, 1'b1);
    checkOutput("partial_tile_done", 64'(done_seen - d0), 64'd2);
    for (int i = 0; i < 2; i++) applyStimulus(rand_data());
    wait_idle();
    checkOutput("full_tile_done", 64'(done_seen - d0), 64'd3);

    // Config rejected mid-tile and with zero tile length.
    applyStimulus(rand_data());
    e0 = err_seen;
    load_cfg(9, 8'd7, 1'b1, 5);
    checkOutput("midtile_cfg_err", cfg_err, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(rand_data());
    wait_idle();
    rst = 1'b1; tick(); rst = 1'b0;
    load_cfg(0, 8'd0, 1'b0, 0);
    checkOutput("zero_tile_cfg_err", cfg_err, 1'b1);
    checkOutput("zero_tile_idle", acc_ready, 1'b0);
    tick();
    checkOutput("cfg_err_one_cycle", cfg_err, 1'b0);
    checkOutput("cfg_err_count", 64'(err_seen - e0), 64'd2);

    // Reset with beats in flight, then a clean restart.
    load_cfg(3, 8'd2, 1'b0, 4);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(rand_data());
    repeat (3) tick();
    checkOutput("inflight_tvalid", m_axis_tvalid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("rst_acc_ready", acc_ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_beats_sent", beats_sent, 32'd0);
    load_cfg(3, 8'd2, 1'b0, 2);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(rand_data());
    wait_idle();
    checkOutput("restart_beats_sent", beats_sent, 32'd2);

    // Random configurations and traffic.
    for (int r = 0; r < 8; r++) begin
      int tile;
      tile = $urandom_range(1, 5);
      load_cfg((r < 4) ? $urandom_range(0, 12) : $urandom_range(0, 31),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), tile);
      run_random(tile * $urandom_range(1, 4));
      wait_idle();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
